// File: rtl/mealy_10010_detector.sv
// Overlapping serial detector for the bit pattern 1-0-0-1-0 on j.
// pre is the raw Mealy flag; post is the same flag registered one clock later.
module mealy_10010_detector (
   input  logic clk,
   input  logic rst,
   input  logic j,
   output logic pre,
   output logic post
);

   // Each state names the longest pattern prefix that is a suffix of the input so far.
   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   post_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S0;
         post_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         post_q  <= pre;
      end
   end

   always_comb begin
      state_d = state_q;
      pre     = 1'b0;
      unique case (state_q)
         S0: state_d = j ? S1 : S0;
         S1: state_d = j ? S1 : S2;
         S2: state_d = j ? S1 : S3;
         S3: state_d = j ? S4 : S0;
         S4: begin
            // Detect arc keeps the trailing "10" so overlapping matches are found.
            state_d = j ? S1 : S2;
            pre     = ~j;
         end
         default: state_d = S0;
      endcase
   end

   assign post = post_q;

endmodule

// File: tb/tb_mealy_10010_detector.sv
// Self-checking bench for mealy_10010_detector: directed scenarios plus randomized
// stream, compared every cycle against a bit-history reference model.
module tb_mealy_10010_detector;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic j   = 1'b0;
   logic pre, post;

   int n_cmp = 0;
   int n_bad = 0;

   mealy_10010_detector dut (
      .clk  (clk),
      .rst  (rst),
      .j    (j),
      .pre  (pre),
      .post (post)
   );

   always #10 clk = ~clk;

   // Reference: remember the last four sampled bits since reset. A detect happens
   // whenever those four are 1,0,0,1 and the present bit is 0.
   logic [3:0] hist;
   int         cnt;
   logic       post_m;
   logic       pre_m;

   assign pre_m = rst && (cnt >= 4) && (hist == 4'b1001) && !j;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist   <= 4'b0000;
         cnt    <= 0;
         post_m <= 1'b0;
      end else begin
         hist   <= {hist[2:0], j};
         cnt    <= (cnt < 4) ? cnt + 1 : 4;
         post_m <= pre_m;
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison, mid-cycle when inputs are stable.
   always @(negedge clk) begin
      check("cycle_pre", pre, pre_m);
      check("cycle_post", post, post_m);
   end

   // Drive one bit; returns 2 ns after the edge that sampled it.
   task automatic send(input logic b);
      j = b;
      @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      rst = 1'b0;
      #5;
      rst = 1'b1;
   endtask

   initial begin
      // 1: reset held, j toggling
      for (int i = 0; i < 4; i++) begin
         j = ~j;
         #7;
         check("rst_pre", pre, 1'b0);
         check("rst_post", post, 1'b0);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;

      // 2: basic 10010
      send(1'b1); send(1'b0); send(1'b0); send(1'b1);
      check("pre_before_last", pre, 1'b0);
      j = 1'b0;
      #3;
      check("detect_pre", pre, 1'b1);
      check("detect_post_not_yet", post, 1'b0);
      @(posedge clk);
      #2;
      check("detect_post", post, 1'b1);
      check("detect_pre_after", pre, 1'b0);

      // 3: overlap continuation 0,1,0
      send(1'b0);
      check("post_one_cycle", post, 1'b0);
      send(1'b1);
      j = 1'b0;
      #3;
      check("overlap_pre", pre, 1'b1);
      @(posedge clk);
      #2;
      check("overlap_post", post, 1'b1);

      // 4: near misses
      reset_pulse();
      send(1'b1); send(1'b0); send(1'b0); send(1'b0); send(1'b1); send(1'b0);
      check("miss1_pre", pre, 1'b0);
      check("miss1_post", post, 1'b0);
      reset_pulse();
      send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0);
      check("miss2_pre", pre, 1'b0);
      check("miss2_post", post, 1'b0);

      // 5: async reset while pre=1, and while post=1
      reset_pulse();
      send(1'b1); send(1'b0); send(1'b0); send(1'b1);
      j = 1'b0;
      #3;
      check("s4_pre", pre, 1'b1);
      rst = 1'b0;
      #1;
      check("async_pre", pre, 1'b0);
      check("async_post", post, 1'b0);
      #4;
      rst = 1'b1;
      #1;
      check("history_gone", pre, 1'b0);
      @(posedge clk);
      #2;
      check("no_post_after_rst", post, 1'b0);
      send(1'b0); send(1'b1);
      check("partial_no_post", post, 1'b0);
      send(1'b0); send(1'b0); send(1'b1); send(1'b0);
      check("full_again_post", post, 1'b1);
      rst = 1'b0;
      #1;
      check("async_post_drop", post, 1'b0);
      #4;
      rst = 1'b1;

      // 6: glitch while in S4
      @(posedge clk);
      #2;
      send(1'b1); send(1'b0); send(1'b0); send(1'b1);
      j = 1'b0; #1; check("glitch_pre0", pre, 1'b1);
      j = 1'b1; #1; check("glitch_pre1", pre, 1'b0);
      check("glitch_post1", post, 1'b0);
      j = 1'b0; #1; check("glitch_pre2", pre, 1'b1);
      check("glitch_post2", post, 1'b0);
      @(posedge clk);
      #2;
      check("glitch_post_edge", post, 1'b1);

      // Randomized stream, biased toward the pattern's bits, with rare resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) reset_pulse();
         send(logic'($urandom_range(0, 99) < 45));
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
